// File: rtl/cdr_pkg.sv
// Shared types and constants for the MSK chip transmit path.
package cdr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } tx_state_t;

  localparam logic [1:0] TICK_PHASE = 2'd3;
  localparam int         NBP_MIN    = 2;

endpackage

// File: rtl/tx_sample_counter.sv
// Sample-tick detection and per-chip sample counter with chip-boundary flag.
module tx_sample_counter
  import cdr_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       cnt_d,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] nbp,
  output logic             tick,
  output logic             boundary
);

  logic [CNT_W-1:0] cnt;

  assign tick     = (cnt_d == TICK_PHASE);
  assign boundary = en && tick && (cnt == nbp - CNT_W'(1));

  // Wraps to zero on the boundary tick so the next chip starts counting at 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && tick) begin
      cnt <= boundary ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/msk_chip_tx.sv
// MSK chip transmitter: buffers chips over valid/ready and holds o_dir = ~chip for nb_P sample ticks.
module msk_chip_tx
  import cdr_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CNT_W-1:0] i_nb_P,
  input  logic [1:0]       i_cnt_d,
  input  logic             i_start,
  input  logic             i_chip,
  input  logic             i_chip_valid,
  input  logic             i_chip_last,
  output logic             o_chip_ready,
  output logic             o_dir,
  output logic             o_sample,
  output logic             o_flag,
  output logic             o_done,
  output logic             o_underrun,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] NBP_MIN_W = CNT_W'(NBP_MIN);

  tx_state_t        state, state_nxt;
  logic             buf_chip, buf_last, buf_vld;
  logic             cur_last, last_seen;
  logic [CNT_W-1:0] nbp_r;
  logic             tick, boundary, in_run;
  logic             arm_load, run_load, consume, accept;
  logic             done_nxt, under_nxt;

  assign in_run = (state == RUN);
  assign o_busy = (state != IDLE);

  tx_sample_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .cnt_d    (i_cnt_d),
    .en       (in_run),
    .clr      (!in_run),
    .nbp      (nbp_r),
    .tick     (tick),
    .boundary (boundary)
  );

  // Ready also opens on the cycle the buffered chip is consumed, so chips can stream back to back.
  always_comb begin
    state_nxt    = state;
    done_nxt     = 1'b0;
    under_nxt    = 1'b0;
    arm_load     = (state == ARM) && tick && buf_vld;
    run_load     = boundary && !cur_last && buf_vld;
    consume      = arm_load || run_load;
    o_chip_ready = (state != IDLE) && !last_seen && (!buf_vld || consume);
    accept       = i_chip_valid && o_chip_ready;
    case (state)
      IDLE: if (i_start) state_nxt = ARM;
      ARM:  if (arm_load) state_nxt = RUN;
      RUN: begin
        if (boundary) begin
          if (cur_last) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (!buf_vld) begin
            state_nxt = IDLE;
            under_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_dir      <= 1'b0;
      o_sample   <= 1'b0;
      o_flag     <= 1'b0;
      o_done     <= 1'b0;
      o_underrun <= 1'b0;
      buf_chip   <= 1'b0;
      buf_last   <= 1'b0;
      buf_vld    <= 1'b0;
      cur_last   <= 1'b0;
      last_seen  <= 1'b0;
      nbp_r      <= NBP_MIN_W;
    end else begin
      o_sample   <= in_run && tick;
      o_flag     <= arm_load;
      o_done     <= done_nxt;
      o_underrun <= under_nxt;
      if (state == IDLE && i_start) begin
        nbp_r <= (i_nb_P < NBP_MIN_W) ? NBP_MIN_W : i_nb_P;
      end
      if (consume) begin
        o_dir    <= ~buf_chip;
        cur_last <= buf_last;
      end else if (done_nxt || under_nxt) begin
        o_dir <= 1'b0;
      end
      // Leaving the frame drops anything still buffered, including a chip accepted on an underrun tick.
      if (state_nxt == IDLE) begin
        buf_vld   <= 1'b0;
        last_seen <= 1'b0;
      end else begin
        if (accept) begin
          buf_chip <= i_chip;
          buf_last <= i_chip_last;
          buf_vld  <= 1'b1;
        end else if (consume) begin
          buf_vld <= 1'b0;
        end
        if (accept && i_chip_last) begin
          last_seen <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/msk_chip_tx.md
# msk_chip_tx

Transmit-side counterpart of the CDR decision stage. Accepts a chip stream over a valid/ready handshake and emits the per-sample frequency-direction signal `o_dir` driving the TX modulator: `o_dir` is held for `nb_P` sample ticks per chip and equals `~chip`, the inverse of the receiver's `o_data = ~i_dir` rule. Also emits a frame-alignment pulse, plus frame-done and underrun status. Sits between the chip spreader and the DAC/NCO front end, clocked on the same sample-phase prescaler (`i_cnt_d`) as the RX path.

## Interface
- `CNT_W`, default 6: width of samples-per-chip input and internal counter.
- `i_clk` in 1: system clock.
- `i_rst` in 1: reset, synchronous, active-low.
- `i_nb_P` in `CNT_W`: samples per chip; captured at frame start.
- `i_cnt_d` in 2: sample-phase prescaler; a sample tick is any cycle with `i_cnt_d == 3`.
- `i_start` in 1: one-cycle frame start request; honoured only in IDLE.
- `i_chip` in 1: chip value.
- `i_chip_valid` in 1: `i_chip` valid.
- `i_chip_last` in 1: qualifies the final chip of the frame; meaningful only with `i_chip_valid`.
- `o_chip_ready` out 1: block accepts a chip this cycle.
- `o_dir` out 1: direction to modulator.
- `o_sample` out 1: one-cycle pulse, one cycle after each tick while RUN; marks `o_dir` as sampled.
- `o_flag` out 1: one-cycle pulse at the first sample of the first chip of a frame.
- `o_done` out 1: one-cycle pulse after the last sample of the last chip.
- `o_underrun` out 1: one-cycle pulse when a chip boundary finds no buffered chip.
- `o_busy` out 1: high in ARM or RUN.

## Operation
- One-entry chip buffer (`buf_chip`, `buf_last`, `buf_vld`).
- `o_chip_ready = buf_vld == 0` OR (the buffer is consumed this cycle), in ARM or RUN only. Ready is 0 in IDLE.
- A transfer occurs when valid and ready are both high.
- Counter `cnt`, `CNT_W` bits. It advances only on ticks in RUN. The chip boundary is the tick where `cnt == nbp_r - 1`.
- `nbp_r` is captured from `i_nb_P` when `i_start` is accepted. Values below 2 are clamped to 2. Later changes are ignored until the next start.
- States:
  - IDLE: `o_dir = 0`, `cnt = 0`, buffer empty. `i_start` goes to ARM.
  - ARM: wait for a tick with `buf_vld`. At that edge: `o_dir <= ~buf_chip`, `cnt <= 0`, buffer consumed, `o_flag` pulses next cycle, go to RUN.
  - RUN: on a non-boundary tick, `cnt <= cnt + 1`. On a boundary tick:
    - If the current chip was last: go to IDLE, `o_done` pulse, `o_dir <= 0`.
    - Else if `buf_vld`: load the next chip, `cnt <= 0`.
    - Else: `o_underrun` pulse, `o_dir <= 0`, go to IDLE.
- `i_start` in ARM or RUN is ignored.
- A chip with `i_chip_last` set ends the frame at its final sample. Ready stays low afterwards until IDLE.

## Timing
- Reset (`i_rst == 0` at an edge): state IDLE, all outputs 0, buffer cleared, `cnt` 0. Reset mid-frame aborts with no `o_done` and no `o_underrun`.
- Latency: `o_dir` changes on the clock edge closing the boundary tick (ARM: first tick with a buffered chip).
- `o_sample` and `o_flag` are registered: they appear one cycle after their tick.
- A chip accepted in the same cycle as a boundary tick with an empty buffer does not rescue the boundary: underrun. Chips must be buffered at least one cycle before the boundary.
- A boundary consume and a new accept in the same cycle are legal. The buffer stays full with the new chip.
- `o_dir` is stable for exactly `nbp_r` ticks per chip.

## Structure
- Package `cdr_pkg`:
  - `typedef enum logic [1:0] {IDLE, ARM, RUN}`
  - `TICK_PHASE = 2'd3`
  - `NBP_MIN = 2`
- Sub-module `tx_sample_counter`: tick detect, `cnt`, and boundary flag, with a `clr` input.

## Test plan
- `nb_P=4`, chips 1,0,1 (last on the third), always valid: `o_dir` = 0 for 4 ticks, then 1 for 4 ticks, then 0 for 4 ticks; `o_flag` once; `o_done` after tick 12; exactly 12 `o_sample` pulses.
- `nb_P=1`: behaves as 2; 2 ticks per chip.
- Valid drops after chip 2 of 5: `o_underrun` at the chip-2 boundary, `o_dir = 0`, state IDLE, no `o_done`.
- `i_nb_P` changed 4→8 mid-frame: chip length stays 4 ticks until the next `i_start`.
- `i_rst` low for one cycle mid-chip: all outputs 0 next cycle, `o_chip_ready = 0`. A new `i_start` then restarts cleanly.
- `i_start` held during RUN, and valid with backpressure: no restart, no chip lost or duplicated. The scoreboard compares the `~chip` sequence with `o_dir`.
